count_ctrl: RTL and testbench
=============================

// Module: count_ctrl
// PURPOSE
//   Run controller sitting directly upstream of the 8-bit loadable counter (count8a/count8b).
//   Drives the counter's load/EN/CNT_In inputs and watches its CNT output.
//   Each run loads a preset, counts until CNT equals a programmed limit, freezes the counter there,
//   then reports completion. Supports pause, abort and back-to-back runs.
// PARAMETERS
//   W   8   counter data width; must match the downstream counter
// PORTS
//   clk      in   1   system clock, rising edge; the single clock of the block
//   res      in   1   asynchronous, active-low reset; shared with the downstream counter
//   start    in   1   request a run; sampled only in IDLE
//   stop     in   1   abort the current run; sampled in LOAD and RUN
//   pause    in   1   level; while high in RUN, counting is suspended
//   preset   in   W   start value; captured on an accepted start
//   limit    in   W   terminal value; captured on an accepted start
//   CNT      in   W   current value fed back from the counter
//   load     out  1   to counter load
//   EN       out  1   to counter EN
//   CNT_In   out  W   to counter CNT_In; holds the captured preset
//   busy     out  1   high in LOAD and RUN
//   done     out  1   one-cycle pulse when a run completes
//   aborted  out  1   one-cycle pulse when a run is stopped
// BEHAVIOUR
//   Reset (res=0, async)
//   - state=IDLE; load=EN=busy=done=aborted=0; CNT_In=0; captured preset and limit are 0.
//   - Reset asserted mid-run drops every output within the same cycle; no done/aborted pulse is produced.
//   States: IDLE, LOAD, RUN, DONE, ABORT (codes 0..4). All outputs are Moore except EN.
//   - IDLE: load=EN=0. On start=1, capture preset->CNT_In and limit->lim_q, then go to LOAD.
//   - LOAD: load=1, EN=0, busy=1, for exactly one cycle. Next state is RUN, or ABORT if stop=1.
//     The counter takes CNT_In at the edge that leaves LOAD.
//   - RUN: busy=1; EN = (CNT != lim_q) & ~pause (combinational).
//       stop=1            -> ABORT  (stop wins over a simultaneous match)
//       CNT==lim_q        -> DONE
//       otherwise         -> stay in RUN
//   - DONE: done=1 for one cycle, then IDLE.
//   - ABORT: aborted=1 for one cycle, then IDLE.
//   EN is never high when CNT==lim_q, so the counter never overshoots the limit. It holds at lim_q after DONE.
//   Latency
//   - start sampled at edge k; load is high in cycle k+1; CNT=preset from edge k+2.
//   - done is high in the cycle after the edge at which CNT==lim_q is first seen in RUN.
//   - Counting cycles = (lim_q - preset) mod 2^W, plus any paused cycles.
//   Boundary conditions
//   - Wrap-around: limit < preset counts through 2^W-1 -> 0; mod-2^W arithmetic.
//   - preset==limit: zero EN cycles; RUN exits at its first edge. done is high 2 cycles after load.
//   - start outside IDLE is ignored, including in DONE and ABORT; start held high retriggers on return to IDLE.
//   - preset/limit changes after capture have no effect on the current run.
//   - stop in IDLE or DONE is ignored. pause outside RUN is ignored.
//   - CNT changing externally (counter reset) during RUN is simply tracked.
// STRUCTURE
//   - Shared include count_defs.vh: state code localparams (S_IDLE..S_ABORT) and default width COUNT_W=8.
//     The counter and its benches use the same file.
//   - No sub-module: single FSM plus capture registers.
//   - The counter is instantiated beside this block at top level, not inside it.
// TESTING (bench instantiates count_ctrl + count8a, checks against count8b as reference)
//   1. preset=0x11, limit=0x15, start pulse -> load high 1 cycle, EN high 4 cycles,
//      CNT 11,12,13,14,15, done 1 cycle, CNT holds 0x15.
//   2. preset=0xFE, limit=0x01 -> CNT FE,FF,00,01; 3 EN cycles; done once.
//   3. preset=limit=0x40 -> load 1 cycle, EN never high, done 2 cycles after load, CNT=0x40.
//   4. preset=0x00, limit=0x0A, pause high for 5 cycles at CNT=0x03
//      -> CNT holds 0x03 for 5 cycles, done after 10 EN cycles total.
//   5. Run 0x00->0xFF; stop at CNT=0x20 together with start
//      -> aborted 1 cycle, no done, start ignored, CNT frozen at 0x20.
//   6. res=0 mid-run at CNT=0x08 -> all outputs 0 immediately.
//      After release, a new start with preset=0x05, limit=0x07 completes normally.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the counter run controller: width and state codes.
package count_ctrl_pkg;
  localparam int COUNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;
endpackage

// File: rtl/count_ctrl_if.sv
// Control/feedback bundle between the run controller (master) and its environment (slave).
interface count_ctrl_if import count_ctrl_pkg::*; #(parameter int W = COUNT_W) ();
  logic         start;
  logic         stop;
  logic         pause;
  logic [W-1:0] preset;
  logic [W-1:0] limit;
  logic [W-1:0] CNT;
  logic         load;
  logic         EN;
  logic [W-1:0] CNT_In;
  logic         busy;
  logic         done;
  logic         aborted;

  modport master (
    input  start, stop, pause, preset, limit, CNT,
    output load, EN, CNT_In, busy, done, aborted
  );

  modport slave (
    output start, stop, pause, preset, limit, CNT,
    input  load, EN, CNT_In, busy, done, aborted
  );
endinterface

// File: rtl/count_ctrl.sv
// Run controller for a loadable counter: load preset, count to limit, freeze, pulse done/aborted.
// Latency: load one cycle after start, done one cycle after match; start is ignored unless idle.
module count_ctrl import count_ctrl_pkg::*; #(
  parameter int W = COUNT_W
) (
  input  logic        clk,
  input  logic        res,
  count_ctrl_if.master bus
);

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_preset;
  logic [W-1:0]   r_lim;
  logic           w_match;
  logic           w_load;
  logic           w_en;
  logic           w_busy;
  logic           w_done;
  logic           w_aborted;

  assign w_match = (bus.CNT == r_lim);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Preset and limit are frozen for the whole run once a start is accepted.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_preset <= '0;
      r_lim    <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_preset <= bus.preset;
      r_lim    <= bus.limit;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_en      = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_aborted = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_busy = 1'b1;
        w_next = bus.stop ? S_ABORT : S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        // Gating on the match keeps the counter parked exactly on the limit.
        w_en   = ~w_match & ~bus.pause;
        if (bus.stop)     w_next = S_ABORT;
        else if (w_match) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ABORT: begin
        w_aborted = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.load    = w_load;
  assign bus.EN      = w_en;
  assign bus.CNT_In  = r_preset;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.aborted = w_aborted;

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl driving a behavioural loadable counter; table, hand and random runs.
module tb_count_ctrl;
  logic clk = 1'b0;
  logic res;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  count_ctrl_if bus ();

  count_ctrl dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  // Downstream counter stand-in: load wins over EN, shares the reset.
  logic [7:0] cnt_q;
  always_ff @(posedge clk or negedge res) begin
    if (!res)          cnt_q <= 8'h00;
    else if (bus.load) cnt_q <= bus.CNT_In;
    else if (bus.EN)   cnt_q <= cnt_q + 8'd1;
  end
  assign bus.CNT = cnt_q;

  typedef struct {
    logic [7:0] pre;
    logic [7:0] lim;
    int         p_at;
    int         p_len;
    int         exp_en;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete run; exp_lat is the cycle distance from the load cycle to the done cycle.
  task automatic do_run(input string tag, input logic [7:0] pre, input logic [7:0] lim,
                        input int p_at, input int p_len, input int exp_en, input int exp_lat);
    int cyc, load_n, en_n, done_n, ab_n, load_c, done_c, trace_err, hold_n, rem;
    bit p_used, fin;
    logic [7:0] exp_cnt;
    cyc = 0; load_n = 0; en_n = 0; done_n = 0; ab_n = 0; trace_err = 0; hold_n = 0; rem = 0;
    load_c = -1; done_c = -1000; p_used = 0; fin = 0; exp_cnt = pre;
    @(negedge clk);
    bus.start = 1'b1; bus.preset = pre; bus.limit = lim;
    @(negedge clk);
    bus.start = 1'b0;
    while (!fin && cyc < 700) begin
      bus.preset = 8'($urandom);
      bus.limit  = 8'($urandom);
      if (rem > 0) begin
        bus.pause = 1'b1; rem--;
      end else if (!p_used && p_len > 0 && bus.busy && !bus.load && int'(bus.CNT) == p_at) begin
        bus.pause = 1'b1; rem = p_len - 1; p_used = 1;
      end else begin
        bus.pause = 1'b0;
      end
      #1;
      if (bus.load) begin load_n++; load_c = cyc; exp_cnt = pre; end
      if (bus.busy && !bus.load) begin
        if (bus.CNT != exp_cnt) trace_err++;
        if (bus.EN != ((exp_cnt != lim) && !bus.pause)) trace_err++;
        if (int'(bus.CNT) == p_at) hold_n++;
        if (bus.EN) en_n++;
        if (!bus.pause && exp_cnt != lim) exp_cnt = exp_cnt + 8'd1;
      end
      if (bus.done)    begin done_n++; done_c = cyc; fin = 1; end
      if (bus.aborted) begin ab_n++; fin = 1; end
      cyc++;
      @(negedge clk);
    end
    bus.pause = 1'b0;
    chk({tag, "_load_cycles"}, load_n, 1);
    chk({tag, "_en_cycles"}, en_n, exp_en);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_abort_pulses"}, ab_n, 0);
    chk({tag, "_done_latency"}, done_c - load_c, exp_lat);
    chk({tag, "_cnt_en_trace"}, trace_err, 0);
    chk({tag, "_pause_hold"}, hold_n, (p_at >= 0) ? p_len + 1 : 0);
    #1;
    chk({tag, "_idle_busy"}, int'(bus.busy), 0);
    chk({tag, "_idle_en"}, int'(bus.EN), 0);
    @(negedge clk); #1;
    chk({tag, "_cnt_hold"}, int'(bus.CNT), int'(lim));
  endtask

  // Returns at negedge+1 of the first RUN cycle showing CNT==v.
  task automatic wait_run_cnt(input logic [7:0] v, output bit ok);
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      #1;
      if (bus.busy && !bus.load && bus.CNT == v) ok = 1;
      else @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    bit ok;
    int n_load, n_done, n_ab, l1, l2, d1;
    logic [7:0] pre, lim, tmp;
    int diff, p_at, p_len;

    vecs[0] = '{pre: 8'h11, lim: 8'h15, p_at: -1, p_len: 0, exp_en: 4,   exp_lat: 6};
    vecs[1] = '{pre: 8'hFE, lim: 8'h01, p_at: -1, p_len: 0, exp_en: 3,   exp_lat: 5};
    vecs[2] = '{pre: 8'h40, lim: 8'h40, p_at: -1, p_len: 0, exp_en: 0,   exp_lat: 2};
    vecs[3] = '{pre: 8'h00, lim: 8'h0A, p_at: 3,  p_len: 5, exp_en: 10,  exp_lat: 17};
    vecs[4] = '{pre: 8'h05, lim: 8'h04, p_at: -1, p_len: 0, exp_en: 255, exp_lat: 257};

    res = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.preset = 8'h00; bus.limit = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_load", int'(bus.load), 0);
    chk("rst_en", int'(bus.EN), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_aborted", int'(bus.aborted), 0);
    chk("rst_cnt_in", int'(bus.CNT_In), 0);
    @(negedge clk);
    res = 1'b1;

    for (int i = 0; i < 5; i++)
      do_run($sformatf("vec%0d", i), vecs[i].pre, vecs[i].lim, vecs[i].p_at,
             vecs[i].p_len, vecs[i].exp_en, vecs[i].exp_lat);

    // Stop with start, raised while CNT=1F: that cycle's EN step lands the counter on 20.
    @(negedge clk);
    bus.start = 1'b1; bus.preset = 8'h00; bus.limit = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_run_cnt(8'h1F, ok);
    chk("stop_reach", int'(ok), 1);
    bus.stop = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0; bus.start = 1'b0;
    #1;
    chk("stop_aborted", int'(bus.aborted), 1);
    chk("stop_no_done", int'(bus.done), 0);
    n_load = 0; n_done = 0; n_ab = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      n_load += int'(bus.load); n_done += int'(bus.done); n_ab += int'(bus.aborted);
    end
    chk("stop_after_loads", n_load, 0);
    chk("stop_after_pulses", n_done + n_ab, 0);
    chk("stop_cnt_frozen", int'(bus.CNT), 8'h20);

    // Stop during LOAD.
    @(negedge clk);
    bus.start = 1'b1; bus.preset = 8'h33; bus.limit = 8'h50;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b1;
    #1;
    chk("ldstop_load", int'(bus.load), 1);
    @(negedge clk);
    bus.stop = 1'b0;
    #1;
    chk("ldstop_aborted", int'(bus.aborted), 1);
    chk("ldstop_cnt", int'(bus.CNT), 8'h33);
    @(negedge clk); #1;
    chk("ldstop_pulse_end", int'(bus.aborted), 0);

    // Stop and pause while idle do nothing.
    bus.stop = 1'b1; bus.pause = 1'b1;
    n_ab = 0; n_load = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_ab += int'(bus.aborted); n_load += int'(bus.busy);
    end
    bus.stop = 1'b0; bus.pause = 1'b0;
    chk("idle_stop_ignored", n_ab + n_load, 0);

    // Start held high: ignored through RUN and DONE, retriggers from IDLE.
    @(negedge clk);
    bus.start = 1'b1; bus.preset = 8'h10; bus.limit = 8'h12;
    l1 = -1; l2 = -1; d1 = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (bus.load) begin
        if (l1 < 0) l1 = c;
        else if (l2 < 0) l2 = c;
      end
      if (bus.done && d1 < 0) d1 = c;
    end
    bus.start = 1'b0;
    chk("retrig_first_done", d1 - l1, 4);
    chk("retrig_reload", l2 - d1, 2);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk); #1;
      if (!bus.busy && !bus.done) ok = 1;
    end
    chk("retrig_settle", int'(ok), 1);

    // Reset mid-run drops everything at once.
    @(negedge clk);
    bus.start = 1'b1; bus.preset = 8'h00; bus.limit = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_run_cnt(8'h08, ok);
    chk("rst_mid_reach", int'(ok), 1);
    res = 1'b0;
    #1;
    chk("rst_mid_outs", int'({bus.load, bus.EN, bus.busy, bus.done, bus.aborted}), 0);
    chk("rst_mid_cnt_in", int'(bus.CNT_In), 0);
    @(negedge clk);
    res = 1'b1;
    do_run("rst_rerun", 8'h05, 8'h07, -1, 0, 2, 4);

    // Random runs checked against arithmetic expectations.
    for (int r = 0; r < 16; r++) begin
      pre   = 8'($urandom);
      diff  = (r % 4 == 3) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      lim   = pre + 8'(diff);
      p_len = int'($urandom_range(0, 6));
      if (diff > 0) begin
        tmp  = pre + 8'($urandom_range(0, diff - 1));
        p_at = int'(tmp);
      end else begin
        p_at = -1;
      end
      do_run($sformatf("rnd%0d", r), pre, lim, p_at, p_len, diff,
             diff + ((p_at >= 0) ? p_len : 0) + 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
